alert_ping_sched: RTL and testbench



---
 rtl/alert_ping_sched.sv | 144 ++++++++++++++
 tb/tb_alert_ping_sched.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alert_ping_sched.sv
// alert_ping_sched: pings one enabled alert receiver at a time in round-robin order and flags unanswered pings.
// Define ALERT_PING_SCHED_LFSR_EN to randomise the wait interval with a 16-bit Galois LFSR.
module alert_ping_sched #(
  parameter int          NAlerts  = 4,
  parameter int          CntW     = 16,
  parameter logic [15:0] LfsrSeed = 16'hACE1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       en_i,
  input  logic [CntW-1:0]            wait_mask_i,
  input  logic [CntW-1:0]            timeout_i,
  input  logic [NAlerts-1:0]         alert_en_i,
  input  logic [NAlerts-1:0]         ping_ok_i,
  output logic [NAlerts-1:0]         ping_en_o,
  output logic                       ping_fail_o,
  output logic [$clog2(NAlerts)-1:0] ping_fail_id_o
);
  localparam int IdW = $clog2(NAlerts);

  typedef enum logic [1:0] {IDLE, WAIT, PING} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    wcnt_q, wcnt_d, tcnt_q, tcnt_d, w_cur, w_adv;
  logic [IdW-1:0]     sel_q, sel_d, last_q, last_d, fail_id_q, fail_id_d, nxt_id, lo_id;
  logic [NAlerts-1:0] ping_en_q, ping_en_d;
  logic               fail_q, fail_d, hi_hit, any_en, ok_sel, en_sel, lfsr_adv;

  if (LfsrSeed == 16'h0000) begin : g_seed_chk
    $error("LfsrSeed must be non-zero");
  end

  assign any_en = |alert_en_i;
  assign ok_sel = ping_ok_i[sel_q];
  assign en_sel = alert_en_i[sel_q];

  // Lowest enabled index above last_q, else lowest enabled index overall (wrap).
  always_comb begin
    hi_hit = 1'b0;
    nxt_id = '0;
    lo_id  = '0;
    for (int i = NAlerts - 1; i >= 0; i--) begin
      if (alert_en_i[i]) begin
        lo_id = IdW'(i);
        if (i > int'(last_q)) begin
          hi_hit = 1'b1;
          nxt_id = IdW'(i);
        end
      end
    end
    if (!hi_hit) nxt_id = lo_id;
  end

`ifdef ALERT_PING_SCHED_LFSR_EN
  logic [15:0] lfsr_q, lfsr_d, lfsr_nxt;

  assign lfsr_nxt = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign lfsr_d   = lfsr_adv ? lfsr_nxt : lfsr_q;
  assign w_cur    = CntW'(lfsr_q) & wait_mask_i;
  assign w_adv    = CntW'(lfsr_nxt) & wait_mask_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= LfsrSeed;
    else         lfsr_q <= lfsr_d;
  end
`else
  assign w_cur = wait_mask_i;
  assign w_adv = wait_mask_i;
`endif

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    tcnt_d    = tcnt_q;
    sel_d     = sel_q;
    last_d    = last_q;
    ping_en_d = ping_en_q;
    fail_d    = 1'b0;
    fail_id_d = fail_id_q;
    lfsr_adv  = 1'b0;
    if (!en_i) begin
      state_d   = IDLE;
      ping_en_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          wcnt_d  = w_cur;
          state_d = WAIT;
        end
        WAIT: begin
          if (wcnt_q != '0) wcnt_d = wcnt_q - 1'b1;
          else if (!any_en) wcnt_d = w_cur;
          else begin
            sel_d     = nxt_id;
            tcnt_d    = timeout_i;
            ping_en_d = {{(NAlerts-1){1'b0}}, 1'b1} << nxt_id;
            state_d   = PING;
          end
        end
        PING: begin
          // Ack beats a coincident timeout; a disabled target aborts silently.
          if (ok_sel || !en_sel || tcnt_q == '0) begin
            lfsr_adv  = ok_sel || en_sel;
            fail_d    = !ok_sel && en_sel;
            fail_id_d = (!ok_sel && en_sel) ? sel_q : fail_id_q;
            wcnt_d    = (ok_sel || en_sel) ? w_adv : w_cur;
            last_d    = sel_q;
            ping_en_d = '0;
            state_d   = WAIT;
          end else begin
            tcnt_d = tcnt_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      tcnt_q    <= '0;
      sel_q     <= '0;
      last_q    <= IdW'(NAlerts - 1);
      ping_en_q <= '0;
      fail_q    <= 1'b0;
      fail_id_q <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      tcnt_q    <= tcnt_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      ping_en_q <= ping_en_d;
      fail_q    <= fail_d;
      fail_id_q <= fail_id_d;
    end
  end

  assign ping_en_o      = ping_en_q;
  assign ping_fail_o    = fail_q;
  assign ping_fail_id_o = fail_id_q;
endmodule

// File: tb/tb_alert_ping_sched.sv
// tb_alert_ping_sched: directed checks of ping order, wait/timeout timing, aborts and reset.
module tb_alert_ping_sched;
  localparam int          N    = 4;
  localparam int          CW   = 16;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          BND  = 400;

  logic          clk = 1'b0;
  logic          rst_n, en;
  logic [CW-1:0] mask, tmo;
  logic [N-1:0]  aen, ok;
  logic [N-1:0]  ping_en_o;
  logic          ping_fail_o;
  logic [1:0]    ping_fail_id_o;

  int          checks = 0, errors = 0, fails_seen = 0, exp_n = 0;
  logic [15:0] m_lfsr = SEED;

  alert_ping_sched #(.NAlerts(N), .CntW(CW), .LfsrSeed(SEED)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .wait_mask_i(mask), .timeout_i(tmo),
    .alert_en_i(aen), .ping_ok_i(ok), .ping_en_o(ping_en_o), .ping_fail_o(ping_fail_o),
    .ping_fail_id_o(ping_fail_id_o)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (ping_fail_o) fails_seen++;

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int ew();
`ifdef ALERT_PING_SCHED_LFSR_EN
    return int'(m_lfsr & mask);
`else
    return int'(mask);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rise(output int n);
    n = 0;
    while (ping_en_o == '0 && n < BND) begin
      tick();
      n++;
    end
  endtask

  task automatic ack_after(input int d);
    repeat (d) tick();
    ok = ping_en_o;
    tick();
    ok = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; mask = 16'd5; tmo = 16'd10; aen = '1; ok = '0;
    repeat (2) tick();
    checks++; if (ping_en_o !== '0) begin errors++; $display("FAIL rst_ping_en got %b want 0000", ping_en_o); end
    checks++; if (ping_fail_o !== 1'b0) begin errors++; $display("FAIL rst_fail got %b want 0", ping_fail_o); end
    checks++; if (ping_fail_id_o !== 2'd0) begin errors++; $display("FAIL rst_fail_id got %0d want 0", ping_fail_id_o); end
    rst_n = 1'b1;
    repeat (5) tick();
    checks++; if (ping_en_o !== '0) begin errors++; $display("FAIL idle_disabled got %b want 0000", ping_en_o); end
    m_lfsr = SEED;
  endtask

  task automatic test_round_robin();
    int idx[5] = '{0, 1, 2, 3, 0};
    int f0 = fails_seen;
    int n;
    exp_n = ew() + 2;
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_rise(n);
      checks++; if (n != exp_n) begin errors++; $display("FAIL rr_gap[%0d] got %0d want %0d", k, n, exp_n); end
      checks++; if (ping_en_o !== N'(1 << idx[k])) begin errors++; $display("FAIL rr_sel[%0d] got %b want %b", k, ping_en_o, N'(1 << idx[k])); end
      tick();
      ok = ~ping_en_o;
      tick();
      ok = '0;
      checks++; if (ping_en_o !== N'(1 << idx[k])) begin errors++; $display("FAIL rr_other_ack[%0d] got %b want %b", k, ping_en_o, N'(1 << idx[k])); end
      ack_after(1);
      checks++; if (ping_en_o !== '0) begin errors++; $display("FAIL rr_drop[%0d] got %b want 0000", k, ping_en_o); end
      m_lfsr = lstep(m_lfsr);
      exp_n = ew() + 1;
    end
    checks++; if (fails_seen != f0) begin errors++; $display("FAIL rr_no_fail got %0d want %0d", fails_seen, f0); end
  endtask

  task automatic test_timeout();
    int n, f0;
    wait_rise(n);
    checks++; if (n != exp_n || ping_en_o !== 4'b0010) begin errors++; $display("FAIL to_pre gap %0d sel %b want %0d 0010", n, ping_en_o, exp_n); end
    ack_after(3);
    m_lfsr = lstep(m_lfsr);
    exp_n = ew() + 1;
    wait_rise(n);
    checks++; if (n != exp_n || ping_en_o !== 4'b0100) begin errors++; $display("FAIL to_ping2 gap %0d sel %b want %0d 0100", n, ping_en_o, exp_n); end
    f0 = fails_seen;
    n = 0;
    while (ping_fail_o !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++; if (n != 11) begin errors++; $display("FAIL to_latency got %0d want 11", n); end
    checks++; if (ping_fail_id_o !== 2'd2) begin errors++; $display("FAIL to_id got %0d want 2", ping_fail_id_o); end
    checks++; if (ping_en_o !== '0) begin errors++; $display("FAIL to_drop got %b want 0000", ping_en_o); end
    tick();
    checks++; if (ping_fail_o !== 1'b0) begin errors++; $display("FAIL to_pulse_width got %b want 0", ping_fail_o); end
    checks++; if (fails_seen - f0 != 1) begin errors++; $display("FAIL to_count got %0d want 1", fails_seen - f0); end
    m_lfsr = lstep(m_lfsr);
    exp_n = ew();
    wait_rise(n);
    checks++; if (n != exp_n || ping_en_o !== 4'b1000) begin errors++; $display("FAIL to_next gap %0d sel %b want %0d 1000", n, ping_en_o, exp_n); end
    ack_after(3);
    m_lfsr = lstep(m_lfsr);
    exp_n = ew() + 1;
  endtask

  task automatic test_mask();
    logic [N-1:0] sel[3] = '{4'b0010, 4'b1000, 4'b0010};
    int n;
    aen = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      wait_rise(n);
      checks++; if (n != exp_n) begin errors++; $display("FAIL mask_gap[%0d] got %0d want %0d", k, n, exp_n); end
      checks++; if (ping_en_o !== sel[k]) begin errors++; $display("FAIL mask_sel[%0d] got %b want %b", k, ping_en_o, sel[k]); end
      ack_after(3);
      m_lfsr = lstep(m_lfsr);
      exp_n = ew() + 1;
    end
    aen = '0;
    wait_rise(n);
    checks++; if (n != BND || ping_en_o !== '0) begin errors++; $display("FAIL mask_none got %0d cycles en %b want %0d 0000", n, ping_en_o, BND); end
    en = 1'b0;
    tick();
    aen = '1;
    tick();
  endtask

  task automatic test_coincide();
    int n, f0;
    tmo = 16'd4;
    exp_n = ew() + 2;
    en = 1'b1;
    wait_rise(n);
    checks++; if (n != exp_n || ping_en_o !== 4'b0100) begin errors++; $display("FAIL co_ping gap %0d sel %b want %0d 0100", n, ping_en_o, exp_n); end
    f0 = fails_seen;
    ack_after(4);
    checks++; if (ping_en_o !== '0 || ping_fail_o !== 1'b0) begin errors++; $display("FAIL co_ack_at_zero en %b fail %b want 0000 0", ping_en_o, ping_fail_o); end
    checks++; if (fails_seen != f0) begin errors++; $display("FAIL co_no_fail got %0d want %0d", fails_seen, f0); end
    m_lfsr = lstep(m_lfsr);
    exp_n = ew() + 1;
    wait_rise(n);
    checks++; if (n != exp_n || ping_en_o !== 4'b1000) begin errors++; $display("FAIL co_ping3 gap %0d sel %b want %0d 1000", n, ping_en_o, exp_n); end
    repeat (5) tick();
    checks++; if (ping_fail_o !== 1'b1 || ping_fail_id_o !== 2'd3) begin errors++; $display("FAIL co_late fail %b id %0d want 1 3", ping_fail_o, ping_fail_id_o); end
    ok = 4'b1000;
    tick();
    ok = '0;
    checks++; if (fails_seen - f0 != 1) begin errors++; $display("FAIL co_late_count got %0d want 1", fails_seen - f0); end
    m_lfsr = lstep(m_lfsr);
    exp_n = ew();
    wait_rise(n);
    checks++; if (n != exp_n || ping_en_o !== 4'b0001) begin errors++; $display("FAIL co_after gap %0d sel %b want %0d 0001", n, ping_en_o, exp_n); end
    ack_after(3);
    m_lfsr = lstep(m_lfsr);
    exp_n = ew() + 1;
    tmo = 16'd10;
  endtask

  task automatic test_abort();
    int n;
    int f0 = fails_seen;
    wait_rise(n);
    checks++; if (n != exp_n || ping_en_o !== 4'b0010) begin errors++; $display("FAIL ab_ping gap %0d sel %b want %0d 0010", n, ping_en_o, exp_n); end
    repeat (2) tick();
    en = 1'b0;
    tick();
    checks++; if (ping_en_o !== '0) begin errors++; $display("FAIL ab_en_drop got %b want 0000", ping_en_o); end
    tick();
    en = 1'b1;
    exp_n = ew() + 2;
    wait_rise(n);
    checks++; if (n != exp_n || ping_en_o !== 4'b0010) begin errors++; $display("FAIL ab_resume gap %0d sel %b want %0d 0010", n, ping_en_o, exp_n); end
    repeat (2) tick();
    aen = 4'b1101;
    tick();
    checks++; if (ping_en_o !== '0 || ping_fail_o !== 1'b0) begin errors++; $display("FAIL ab_alert_dis en %b fail %b want 0000 0", ping_en_o, ping_fail_o); end
    exp_n = ew() + 1;
    wait_rise(n);
    checks++; if (n != exp_n || ping_en_o !== 4'b0100) begin errors++; $display("FAIL ab_next gap %0d sel %b want %0d 0100", n, ping_en_o, exp_n); end
    ack_after(3);
    m_lfsr = lstep(m_lfsr);
    exp_n = ew() + 1;
    aen = '1;
    checks++; if (fails_seen != f0) begin errors++; $display("FAIL ab_no_fail got %0d want %0d", fails_seen, f0); end
  endtask

  task automatic test_async_reset();
    int n;
    wait_rise(n);
    checks++; if (n != exp_n || ping_en_o !== 4'b1000) begin errors++; $display("FAIL ar_ping gap %0d sel %b want %0d 1000", n, ping_en_o, exp_n); end
    tick();
    #2;
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    checks++; if (ping_en_o !== '0) begin errors++; $display("FAIL ar_ping_en got %b want 0000", ping_en_o); end
    checks++; if (ping_fail_o !== 1'b0 || ping_fail_id_o !== 2'd0) begin errors++; $display("FAIL ar_fail got %b id %0d want 0 0", ping_fail_o, ping_fail_id_o); end
    #2;
    rst_n = 1'b1;
    tick();
    m_lfsr = SEED;
  endtask

  task automatic test_lfsr_wait();
    int n;
    mask = 16'h00FF;
    exp_n = ew() + 2;
    en = 1'b1;
    wait_rise(n);
    checks++; if (n != exp_n || ping_en_o !== 4'b0001) begin errors++; $display("FAIL lw_first gap %0d sel %b want %0d 0001", n, ping_en_o, exp_n); end
    ack_after(3);
    m_lfsr = lstep(m_lfsr);
    exp_n = ew() + 1;
    wait_rise(n);
    checks++; if (n != exp_n || ping_en_o !== 4'b0010) begin errors++; $display("FAIL lw_second gap %0d sel %b want %0d 0010", n, ping_en_o, exp_n); end
    ack_after(3);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_timeout();
    test_mask();
    test_coincide();
    test_abort();
    test_async_reset();
    test_lfsr_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
